// File: rtl/sar_search_if.sv
// Comparator-side link of the SAR search controller: candidate A out, verdict back.
// The controller is the master; the comparator (or a model of it) is the slave.

// Handshake: guess is stable while guess_valid=1. Every cycle with
// guess_valid=1 and resp_valid=1 consumes the current guess, and
// resp_lt/resp_eq/resp_gt are meaningful only in that cycle. There is no
// separate ready: the controller is always ready for a verdict in QUERY.
interface sar_search_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             resp_valid;
  logic             resp_lt;
  logic             resp_eq;
  logic             resp_gt;

  modport master (
    output guess,
    output guess_valid,
    input  resp_valid,
    input  resp_lt,
    input  resp_eq,
    input  resp_gt
  );

  modport slave (
    input  guess,
    input  guess_valid,
    output resp_valid,
    output resp_lt,
    output resp_eq,
    output resp_gt
  );
endinterface

// File: rtl/sar_search_controller.sv
// Binary-search controller for an external magnitude comparator (guess = A, target = B).
// Optional macro SAR_SEARCH_STEP_COUNT_EN adds the `steps` transaction counter output.

module sar_search_controller #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  sar_search_if.master                cmp,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic                        error,
  output logic [WIDTH-1:0]            result,
`ifdef SAR_SEARCH_STEP_COUNT_EN
  output logic [$clog2(WIDTH+2)-1:0]  steps,
`endif
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QUERY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bounds carry one extra bit so lo = 2^WIDTH (search passed the top) is visible.
  localparam logic [WIDTH:0] BOUND_ONE = (WIDTH + 1)'(1);
  localparam logic [WIDTH:0] BOUND_MAX = {1'b0, {WIDTH{1'b1}}};

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH:0]   lo_q;
  logic [WIDTH:0]   lo_d;
  logic [WIDTH:0]   hi_q;
  logic [WIDTH:0]   hi_d;
  logic [WIDTH-1:0] guess_q;
  logic [WIDTH-1:0] guess_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic             found_q;
  logic             found_d;
  logic             error_q;
  logic             error_d;

  logic             txn;
  logic             verdict_ok;
  logic [WIDTH:0]   lo_inc;
  logic [WIDTH:0]   hi_dec;

  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] l,
                                                input logic [WIDTH:0] h);
    logic [WIDTH:0] sum;
    sum = l + ((h - l) >> 1);
    return sum[WIDTH-1:0];
  endfunction

  assign txn        = (state_q == S_QUERY) && cmp.resp_valid;
  assign verdict_ok = $onehot({cmp.resp_lt, cmp.resp_eq, cmp.resp_gt});
  assign lo_inc     = {1'b0, guess_q} + BOUND_ONE;
  assign hi_dec     = {1'b0, guess_q} - BOUND_ONE;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next search-window logic
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    found_d  = found_q;
    error_d  = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_QUERY;
          lo_d     = '0;
          hi_d     = BOUND_MAX;
          guess_d  = midpoint('0, BOUND_MAX);
          result_d = '0;
          found_d  = 1'b0;
          error_d  = 1'b0;
        end
      end

      S_QUERY: begin
        if (txn) begin
          if (!verdict_ok) begin
            error_d = 1'b1;
            found_d = 1'b0;
            state_d = S_DONE;
          end else if (cmp.resp_eq) begin
            result_d = guess_q;
            found_d  = 1'b1;
            state_d  = S_DONE;
          end else if (cmp.resp_lt) begin
            lo_d = lo_inc;
            if (lo_inc > hi_q) begin
              state_d = S_DONE;
            end else begin
              guess_d = midpoint(lo_inc, hi_q);
            end
          end else begin
            // Guess above target: a zero guess means nothing smaller is left.
            if (guess_q == '0) begin
              state_d = S_DONE;
            end else begin
              hi_d = hi_dec;
              if (lo_q > hi_dec) begin
                state_d = S_DONE;
              end else begin
                guess_d = midpoint(lo_q, hi_dec);
              end
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      found_q  <= found_d;
      error_q  <= error_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    cmp.guess       = guess_q;
    cmp.guess_valid = (state_q == S_QUERY);
    busy            = (state_q == S_QUERY);
    done            = (state_q == S_DONE);
    found           = found_q;
    error           = error_q;
    result          = result_q;
    dbg_state       = state_q;
  end

`ifdef SAR_SEARCH_STEP_COUNT_EN
  localparam int STEP_W = $clog2(WIDTH + 2);

  logic [STEP_W-1:0] steps_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      steps_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      steps_q <= '0;
    end else if (txn) begin
      steps_q <= steps_q + STEP_W'(1);
    end
  end

  assign steps = steps_q;
`endif

endmodule

// File: tb/tb_sar_search_controller.sv
// Self-checking bench for sar_search_controller: randomized comparator responder
// plus a behavioural binary-search model checked every cycle at the falling edge.

module tb_sar_search_controller;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic         busy;
  logic         done;
  logic         found;
  logic         error;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;
`ifdef SAR_SEARCH_STEP_COUNT_EN
  logic [$clog2(W+2)-1:0] steps;
`endif

  sar_search_if #(.WIDTH(W)) cmp_if ();

  sar_search_controller #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmp       (cmp_if),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .error     (error),
    .result    (result),
`ifdef SAR_SEARCH_STEP_COUNT_EN
    .steps     (steps),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- comparator responder ----------------
  int resp_target = 0;
  int resp_waits  = 0;
  bit resp_bad    = 1'b0;
  int wait_cnt    = 0;

  always @(posedge clk) begin
    #2;
    if (cmp_if.guess_valid && (wait_cnt >= resp_waits)) begin
      wait_cnt          = 0;
      cmp_if.resp_valid = 1'b1;
      if (resp_bad) begin
        cmp_if.resp_lt = 1'b1;
        cmp_if.resp_eq = 1'b0;
        cmp_if.resp_gt = 1'b1;
      end else begin
        cmp_if.resp_lt = (int'(cmp_if.guess) <  resp_target);
        cmp_if.resp_eq = (int'(cmp_if.guess) == resp_target);
        cmp_if.resp_gt = (int'(cmp_if.guess) >  resp_target);
      end
    end else begin
      wait_cnt          = cmp_if.guess_valid ? wait_cnt + 1 : 0;
      cmp_if.resp_valid = 1'b0;
      // Verdict lines carry junk whenever resp_valid is low.
      cmp_if.resp_lt    = 1'($urandom_range(0, 1));
      cmp_if.resp_eq    = 1'($urandom_range(0, 1));
      cmp_if.resp_gt    = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- behavioural model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_q[$];
  bit           exp_found;
  bit           exp_error;
  int           exp_result;

  // Plain binary search over integers; target < 0 models an "always greater" responder.
  task automatic model_search(input int target, input bit bad);
    int lo;
    int hi;
    int g;
    lo = 0;
    hi = (1 << W) - 1;
    exp_q.delete();
    exp_found  = 1'b0;
    exp_error  = 1'b0;
    exp_result = 0;
    forever begin
      g = lo + (hi - lo) / 2;
      exp_q.push_back(W'(g));
      if (bad) begin
        exp_error = 1'b1;
        break;
      end
      if (g == target) begin
        exp_found  = 1'b1;
        exp_result = g;
        break;
      end
      if (g < target) begin
        lo = g + 1;
        if (lo > hi) break;
      end else begin
        if (g == 0) break;
        hi = g - 1;
        if (lo > hi) break;
      end
    end
    last_q = exp_q;
  endtask

  // ---------------- scoreboard / compare process ----------------
  int mstate   = 0;   // 0 idle, 1 searching, 2 done pulse
  bit h_found  = 1'b0;
  bit h_error  = 1'b0;
  int h_result = 0;
  int h_steps  = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("found_hold", found, h_found);
      check("error_hold", error, h_error);
      check("result_hold", result, h_result);
`ifdef SAR_SEARCH_STEP_COUNT_EN
      check("steps", steps, h_steps);
`endif
      case (mstate)
        0: begin
          check("idle_guess_valid", cmp_if.guess_valid, 0);
          check("idle_busy", busy, 0);
          check("idle_done", done, 0);
          if (start) begin
            mstate  = 1;
            h_found = 1'b0;
            h_error = 1'b0;
            h_result = 0;
            h_steps = 0;
          end
        end
        1: begin
          check("query_guess_valid", cmp_if.guess_valid, 1);
          check("query_busy", busy, 1);
          check("query_done", done, 0);
          if (exp_q.size() == 0) begin
            check("query_model_empty", 1, 0);
          end else begin
            check("guess", cmp_if.guess, exp_q[0]);
            if (cmp_if.resp_valid) begin
              void'(exp_q.pop_front());
              h_steps++;
              if (exp_q.size() == 0) begin
                mstate   = 2;
                h_found  = exp_found;
                h_error  = exp_error;
                h_result = exp_result;
              end
            end
          end
        end
        default: begin
          check("done_pulse", done, 1);
          check("done_guess_valid", cmp_if.guess_valid, 0);
          check("done_busy", busy, 0);
          mstate = 0;
        end
      endcase
    end
    // Reset is sampled at the coming rising edge and wipes any search in flight.
    if (!rst_n) begin
      mstate   = 0;
      exp_q.delete();
      h_found  = 1'b0;
      h_error  = 1'b0;
      h_result = 0;
      h_steps  = 0;
    end
  end

  // ---------------- driver tasks ----------------
  int last_lat = 0;

  task automatic pulse_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic run_search(input int target, input int waits, input bit bad, input bit poke);
    int n_exp;
    int s_cyc;
    bit got;
    model_search(target, bad);
    n_exp       = exp_q.size();
    resp_target = target;
    resp_waits  = waits;
    resp_bad    = bad;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    s_cyc = cyc;
    if (poke) begin
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_within_budget", got, 1);
    if (got) begin
      last_lat = cyc - s_cyc + 1;
      if (waits == 0) check("latency", last_lat, n_exp + 1);
    end else begin
      pulse_reset();
    end
    @(posedge clk); #2;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_guess"}, cmp_if.guess, 0);
    check({tag, "_guess_valid"}, cmp_if.guess_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_found"}, found, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_result"}, result, 0);
`ifdef SAR_SEARCH_STEP_COUNT_EN
    check({tag, "_steps"}, steps, 0);
`endif
  endtask

  task automatic reset_mid_search();
    int n;
    model_search(90, 1'b0);
    resp_target = 90;
    resp_waits  = 0;
    resp_bad    = 1'b0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n < 3; i++) begin
      @(negedge clk);
      if (cmp_if.guess_valid && cmp_if.resp_valid) n++;
    end
    check("three_transactions", n, 3);
    pulse_reset();
    @(negedge clk);
    check_zero_outputs("post_reset");
    @(posedge clk); #2;
  endtask

  // ---------------- main sequence ----------------
  int pin0[8]   = '{127, 63, 31, 15, 7, 3, 1, 0};
  int pin255[9] = '{127, 191, 223, 239, 247, 251, 253, 254, 255};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Target 127: found on the first guess.
    run_search(127, 0, 1'b0, 1'b0);
    check("t127_latency_lit", last_lat, 2);
    check("t127_found_lit", found, 1);
    check("t127_result_lit", result, 127);
    check("t127_model_len", last_q.size(), 1);
`ifdef SAR_SEARCH_STEP_COUNT_EN
    check("t127_steps_lit", steps, 1);
`endif

    // Target 0: walks down to zero without underflow.
    run_search(0, 0, 1'b0, 1'b0);
    check("t0_model_len", last_q.size(), 8);
    for (int i = 0; i < 8 && i < last_q.size(); i++) check("t0_model_pin", last_q[i], pin0[i]);
    check("t0_found_lit", found, 1);
    check("t0_result_lit", result, 0);
`ifdef SAR_SEARCH_STEP_COUNT_EN
    check("t0_steps_lit", steps, 8);
`endif

    // Target 255: top of range, needs WIDTH+1 transactions.
    run_search(255, 0, 1'b0, 1'b0);
    check("t255_model_len", last_q.size(), 9);
    for (int i = 0; i < 9 && i < last_q.size(); i++) check("t255_model_pin", last_q[i], pin255[i]);
    check("t255_found_lit", found, 1);
    check("t255_result_lit", result, 255);
`ifdef SAR_SEARCH_STEP_COUNT_EN
    check("t255_steps_lit", steps, 9);
`endif

    // Responder always says "greater".
    run_search(-1, 0, 1'b0, 1'b0);
    check("allgt_found_lit", found, 0);
    check("allgt_error_lit", error, 0);
    check("allgt_last_guess", last_q[last_q.size()-1], 0);

    // Verdict with lt and gt both set.
    run_search(90, 0, 1'b1, 1'b0);
    check("bad_error_lit", error, 1);
    check("bad_found_lit", found, 0);

    // Three wait cycles per verdict, with an ignored start mid-search.
    run_search(90, 3, 1'b0, 1'b1);
    check("t90_found_lit", found, 1);
    check("t90_result_lit", result, 90);

    // Reset after the third transaction, then a normal search.
    reset_mid_search();
    run_search(200, 0, 1'b0, 1'b0);
    check("after_reset_result_lit", result, 200);

    // Randomized targets and responder latency.
    for (int k = 0; k < 20; k++) begin
      int t;
      int wt;
      t  = int'($urandom_range(0, (1 << W) - 1));
      wt = int'($urandom_range(0, 3));
      run_search(t, wt, 1'b0, (wt >= 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      check("rand_found", found, 1);
      check("rand_result", result, t);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
